// File: rtl/alu_serial_ctrl.sv
// Command sequencer for the serial ALU: accepts one parallel operation, shifts a
// 99-bit CRC4-protected request frame onto sin, and deserializes/checks the reply.
module alu_serial_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_A,
  input  logic [31:0] cmd_B,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_bad_crc,
  output logic        sin,
  input  logic        sout,
  output logic        busy,
  output logic        rsp_valid,
  output logic        rsp_status,
  output logic [31:0] rsp_C,
  output logic [3:0]  rsp_flags,
  output logic        rsp_crc3_ok,
  output logic [5:0]  rsp_err_flags,
  output logic        rsp_parity,
  output logic        rsp_frame_err,
  output logic        rsp_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_DONE} state_t;

  function automatic logic [3:0] crc4_f(input logic [67:0] d);
    logic [67:0] s;
    logic [3:0]  c;
    logic        fb;
    s = d;
    c = '0;
    for (int unsigned i = 0; i < 68; i++) begin
      fb = c[3] ^ s[67];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
      s  = s << 1;
    end
    return c;
  endfunction

  function automatic logic [2:0] crc3_f(input logic [36:0] d);
    logic [36:0] s;
    logic [2:0]  c;
    logic        fb;
    s = d;
    c = '0;
    for (int unsigned i = 0; i < 37; i++) begin
      fb = c[2] ^ s[36];
      c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
      s  = s << 1;
    end
    return c;
  endfunction

  function automatic logic [10:0] pkt_f(input logic typ, input logic [7:0] pl);
    return {1'b0, typ, pl, 1'b1};
  endfunction

  state_t      state_q;
  logic        cmd_ready_q, sin_q, busy_q, rsp_valid_q;
  logic [98:0] frame_q;
  logic [6:0]  tx_cnt_q;
  logic [31:0] to_cnt_q;
  logic [3:0]  rx_cnt_q;
  logic [8:0]  rx_sh_q;
  logic [31:0] rx_c_q;
  logic [2:0]  pkt_cnt_q;
  logic        st_q, ok3_q, par_q, fe_q, to_q;
  logic [31:0] c_q;
  logic [3:0]  fl_q;
  logic [5:0]  ef_q;

  logic [3:0]  crc_d;
  logic [98:0] frame_d;
  logic [9:0]  rx_pkt_d;
  logic        fin_d, data_d, st_d, ok3_d, par_d, fe_d, to_d;
  logic [31:0] c_d;
  logic [3:0]  fl_d;
  logic [5:0]  ef_d;

  always_comb begin
    crc_d    = crc4_f({cmd_B, cmd_A, 1'b1, cmd_op}) ^ {3'b000, cmd_bad_crc};
    frame_d  = {pkt_f(1'b0, cmd_B[31:24]), pkt_f(1'b0, cmd_B[23:16]),
                pkt_f(1'b0, cmd_B[15:8]),  pkt_f(1'b0, cmd_B[7:0]),
                pkt_f(1'b0, cmd_A[31:24]), pkt_f(1'b0, cmd_A[23:16]),
                pkt_f(1'b0, cmd_A[15:8]),  pkt_f(1'b0, cmd_A[7:0]),
                pkt_f(1'b1, {1'b0, cmd_op, crc_d})};
    // {type, payload[7:0], stop} of the packet whose stop bit is on sout now
    rx_pkt_d = {rx_sh_q, sout};
  end

  always_comb begin
    fin_d  = 1'b0;
    data_d = 1'b0;
    st_d   = 1'b1;
    c_d    = '0;
    fl_d   = '0;
    ok3_d  = 1'b0;
    ef_d   = '0;
    par_d  = 1'b0;
    fe_d   = 1'b0;
    to_d   = 1'b0;
    if (state_q == S_WAIT && sout && to_cnt_q == 32'(TIMEOUT_CYCLES)) begin
      fin_d = 1'b1;
      to_d  = 1'b1;
    end
    if (state_q == S_RX && rx_cnt_q == 4'd9) begin
      if (!rx_pkt_d[0]) begin
        fin_d = 1'b1;
        fe_d  = 1'b1;
      end else if (rx_pkt_d[9]) begin
        fin_d = 1'b1;
        if (pkt_cnt_q == 3'd0) begin
          ef_d  = rx_pkt_d[7:2];
          par_d = rx_pkt_d[1];
        end else if (pkt_cnt_q == 3'd4) begin
          st_d  = 1'b0;
          c_d   = rx_c_q;
          fl_d  = rx_pkt_d[7:4];
          ok3_d = (crc3_f({rx_c_q, 1'b0, rx_pkt_d[7:4]}) == rx_pkt_d[3:1]);
        end else begin
          fe_d  = 1'b1;
        end
      end else if (pkt_cnt_q < 3'd4) begin
        data_d = 1'b1;
      end else begin
        fin_d = 1'b1;
        fe_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      sin_q       <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      frame_q     <= '0;
      tx_cnt_q    <= '0;
      to_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      rx_sh_q     <= '0;
      rx_c_q      <= '0;
      pkt_cnt_q   <= '0;
      st_q        <= 1'b0;
      c_q         <= '0;
      fl_q        <= '0;
      ok3_q       <= 1'b0;
      ef_q        <= '0;
      par_q       <= 1'b0;
      fe_q        <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            sin_q       <= frame_d[98];
            frame_q     <= {frame_d[97:0], 1'b1};
            tx_cnt_q    <= 7'd1;
            pkt_cnt_q   <= '0;
            rx_c_q      <= '0;
            state_q     <= S_TX;
          end
        end
        S_TX: begin
          sin_q   <= frame_q[98];
          frame_q <= {frame_q[97:0], 1'b1};
          // WAIT begins while the last stop bit is still on the line
          if (tx_cnt_q == 7'd98) begin
            state_q  <= S_WAIT;
            to_cnt_q <= '0;
          end else begin
            tx_cnt_q <= tx_cnt_q + 7'd1;
          end
        end
        S_WAIT: begin
          sin_q <= 1'b1;
          if (!sout) begin
            state_q  <= S_RX;
            rx_cnt_q <= '0;
            to_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        S_RX: begin
          rx_sh_q  <= rx_pkt_d[8:0];
          rx_cnt_q <= rx_cnt_q + 4'd1;
          if (data_d) begin
            rx_c_q    <= {rx_c_q[23:0], rx_pkt_d[8:1]};
            pkt_cnt_q <= pkt_cnt_q + 3'd1;
            to_cnt_q  <= '0;
            state_q   <= S_WAIT;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
      if (fin_d) begin
        state_q     <= S_DONE;
        rsp_valid_q <= 1'b1;
        busy_q      <= 1'b0;
        st_q        <= st_d;
        c_q         <= c_d;
        fl_q        <= fl_d;
        ok3_q       <= ok3_d;
        ef_q        <= ef_d;
        par_q       <= par_d;
        fe_q        <= fe_d;
        to_q        <= to_d;
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign sin           = sin_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = st_q;
  assign rsp_C         = c_q;
  assign rsp_flags     = fl_q;
  assign rsp_crc3_ok   = ok3_q;
  assign rsp_err_flags = ef_q;
  assign rsp_parity    = par_q;
  assign rsp_frame_err = fe_q;
  assign rsp_timeout   = to_q;

endmodule
